// File: rtl/wishbone_arbiter_2x1_if.sv
// ============================================================================
// Module  : wishbone_interface
// Brief   : Classic Wishbone B4 bus bundle with master/slave views.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wishbone_interface;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_mosi;
   logic [31:0] dat_miso;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, adr, sel, dat_mosi,
      input  dat_miso, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_mosi,
      output dat_miso, ack, err
   );
endinterface

`default_nettype wire

// File: rtl/wishbone_arbiter_2x1.sv
// ============================================================================
// Module  : wishbone_arbiter_2x1
// Brief   : Two-master round-robin Wishbone arbiter with per-transfer timeout.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_arbiter_2x1 #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   wishbone_interface.slave  m0,
   wishbone_interface.slave  m1,
   wishbone_interface.master s,
   output logic [1:0]        grant
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT);
   localparam logic [31:0] c_CNT_MAX = '1;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_owner;
   logic        w_owner_nxt;
   logic        r_last;
   logic        w_last_nxt;
   logic [31:0] r_wait_cnt;
   logic [31:0] w_wait_cnt_nxt;

   logic        w_busy;
   logic        w_own_cyc;
   logic        w_own_stb;
   logic        w_fwd;
   logic        w_to_hit;
   logic        w_ack;
   logic        w_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_last     <= w_last_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Outputs are also masked while rst is high so nothing leaks in the reset cycle.
   assign w_busy    = (r_state == ST_BUSY) && !rst;
   assign w_own_cyc = r_owner ? m1.cyc : m0.cyc;
   assign w_own_stb = r_owner ? m1.stb : m0.stb;
   assign w_to_hit  = (c_TIMEOUT != 32'd0) && w_busy && (r_wait_cnt == c_TIMEOUT);
   assign w_fwd     = w_busy && w_own_cyc;

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_last_nxt     = r_last;
      w_wait_cnt_nxt = '0;
      case (r_state)
         ST_IDLE: begin
            if (m0.cyc || m1.cyc) begin
               w_state_nxt = ST_BUSY;
               if (m0.cyc && m1.cyc) begin
                  w_owner_nxt = ~r_last;
               end else begin
                  w_owner_nxt = m1.cyc;
               end
               w_last_nxt = w_owner_nxt;
            end
         end
         ST_BUSY: begin
            if (!w_own_cyc) begin
               w_state_nxt = ST_IDLE;
            end else if (w_own_stb && !s.ack && !s.err && !w_to_hit) begin
               w_wait_cnt_nxt = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt : r_wait_cnt + 32'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // A timeout cycle drops cyc/stb from the slave's view; a coincident ack still wins.
   assign s.cyc      = w_fwd && !w_to_hit;
   assign s.stb      = w_fwd && w_own_stb && !w_to_hit;
   assign s.we       = w_busy && (r_owner ? m1.we : m0.we);
   assign s.adr      = w_busy ? (r_owner ? m1.adr : m0.adr) : 32'd0;
   assign s.sel      = w_busy ? (r_owner ? m1.sel : m0.sel) : 4'd0;
   assign s.dat_mosi = w_busy ? (r_owner ? m1.dat_mosi : m0.dat_mosi) : 32'd0;

   assign w_ack = w_fwd && s.ack;
   assign w_err = w_fwd && (s.err || (w_to_hit && !s.ack));

   assign m0.ack      = w_ack && !r_owner;
   assign m0.err      = w_err && !r_owner;
   assign m0.dat_miso = (w_fwd && !r_owner) ? s.dat_miso : 32'd0;
   assign m1.ack      = w_ack && r_owner;
   assign m1.err      = w_err && r_owner;
   assign m1.dat_miso = (w_fwd && r_owner) ? s.dat_miso : 32'd0;

   assign grant = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

`default_nettype wire
